// File: rtl/multicycle_control_unit.sv
// Multicycle RV32-style control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// times out stalled memory accesses into a sticky TRAP, and counts retired instructions.
module multicycle_control_unit #(
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg_write,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                jump,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [2:0]          state,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    instret,
    output logic                retire
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int              WAIT_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    logic [2:0]          r_state;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_trap;
    logic [1:0]          r_cause;
    logic [CNT_W-1:0]    r_instret;

    logic [2:0]          w_next;
    logic                w_set_trap;
    logic [1:0]          w_cause;
    logic                w_mem_req, w_mem_we, w_addr_sel, w_ir_write, w_pc_write, w_pc_src;
    logic                w_reg_write, w_alu_src, w_mem_to_reg, w_jump, w_retire;
    logic [ALU_OP_W-1:0] w_alu_op;

    logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_branch;
    logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal, w_timeout;
    logic w_unused;

    assign w_is_r      = (opcode == OP_R);
    assign w_is_i      = (opcode == OP_I);
    assign w_is_load   = (opcode == OP_LOAD);
    assign w_is_store  = (opcode == OP_STORE);
    assign w_is_branch = (opcode == OP_BRANCH);
    assign w_is_jal    = (opcode == OP_JAL);
    assign w_is_jalr   = (opcode == OP_JALR);
    assign w_is_lui    = (opcode == OP_LUI);
    assign w_is_auipc  = (opcode == OP_AUIPC);
    assign w_legal     = w_is_r | w_is_i | w_is_load | w_is_store | w_is_branch
                       | w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;
    // Only funct7[5] distinguishes operations; the remaining bits are don't-care.
    assign w_unused    = ^{funct7[6], funct7[4:0]};

    // A ready strobe on the final allowed cycle still wins over the timeout.
    assign w_timeout   = (r_wait == TIMEOUT_CNT) && !mem_ready;

    always_comb begin
        w_next       = r_state;
        w_set_trap   = 1'b0;
        w_cause      = 2'b00;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_addr_sel   = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_jump       = 1'b0;
        w_retire     = 1'b0;
        w_alu_op     = '0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_req = 1'b1;
                    if (mem_ready) begin
                        w_ir_write = 1'b1;
                        w_pc_write = 1'b1;
                        w_next     = S_DECODE;
                    end else if (w_timeout) begin
                        w_next     = S_TRAP;
                        w_set_trap = 1'b1;
                        w_cause    = 2'b10;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        w_next = S_EXEC;
                    end else begin
                        w_next     = S_TRAP;
                        w_set_trap = 1'b1;
                        w_cause    = 2'b01;
                    end
                end
                S_EXEC: begin
                    w_alu_src = w_is_i | w_is_load | w_is_store | w_is_jalr | w_is_lui | w_is_auipc;
                    if (w_is_r)
                        w_alu_op = ALU_OP_W'({funct7[5], funct3});
                    else if (w_is_i)
                        w_alu_op = ALU_OP_W'({(funct3 == 3'b101) & funct7[5], funct3});
                    else if (w_is_branch)
                        w_alu_op = ALU_OP_W'(4'b1000);
                    else if (w_is_lui)
                        w_alu_op = ALU_OP_W'(4'b1010);
                    else if (w_is_auipc)
                        w_alu_op = ALU_OP_W'(4'b1011);

                    if (w_is_load || w_is_store) begin
                        w_next = S_MEM;
                    end else if (w_is_jal || w_is_jalr) begin
                        w_jump     = 1'b1;
                        w_pc_write = 1'b1;
                        w_pc_src   = 1'b1;
                        w_next     = S_WB;
                    end else if (w_is_branch) begin
                        w_pc_write = zero ^ funct3[0];
                        w_pc_src   = zero ^ funct3[0];
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
                S_MEM: begin
                    w_mem_req  = 1'b1;
                    w_addr_sel = 1'b1;
                    w_mem_we   = w_is_store;
                    if (mem_ready) begin
                        w_retire = w_is_store;
                        w_next   = w_is_store ? S_FETCH : S_WB;
                    end else if (w_timeout) begin
                        w_next     = S_TRAP;
                        w_set_trap = 1'b1;
                        w_cause    = 2'b10;
                    end
                end
                S_WB: begin
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = w_is_load;
                    w_retire     = 1'b1;
                    w_next       = S_FETCH;
                end
                S_TRAP:  w_next = S_TRAP;
                default: w_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_trap    <= 1'b0;
            r_cause   <= 2'b00;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready)
                r_wait <= r_wait + WAIT_W'(1);
            if (w_set_trap) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
            if (w_retire)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign state      = r_state;
    assign trap       = r_trap;
    assign trap_cause = r_cause;
    assign instret    = r_instret;
    assign mem_req    = w_mem_req;
    assign mem_we     = w_mem_we;
    assign addr_sel   = w_addr_sel;
    assign ir_write   = w_ir_write;
    assign pc_write   = w_pc_write;
    assign pc_src     = w_pc_src;
    assign reg_write  = w_reg_write;
    assign alu_src    = w_alu_src;
    assign mem_to_reg = w_mem_to_reg;
    assign jump       = w_jump;
    assign retire     = w_retire;
    assign alu_op     = w_alu_op;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// instruction streams compared every cycle against an instruction-class reference model.
module tb_multicycle_control_unit;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic [6:0] funct7 = 7'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
    logic       reg_write, alu_src, mem_to_reg, jump, retire;
    logic [3:0] alu_op;
    logic [2:0] state;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] instret;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 0;

    multicycle_control_unit #(.ALU_OP_W(4), .MEM_TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .jump(jump),
        .alu_op(alu_op), .state(state), .trap(trap), .trap_cause(trap_cause),
        .instret(instret), .retire(retire)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
        logic reg_write, alu_src, mem_to_reg, jump, retire;
        logic [3:0] alu_op;
    } ctl_t;

    typedef struct packed {
        ctl_t       c;
        logic [2:0] nxt;
        logic       tset;
        logic [1:0] cause;
    } step_t;

    // Instruction classes: 0 illegal, 1 R, 2 I, 3 LOAD, 4 STORE, 5 BRANCH, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC
    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'b0110011: return 1;
            7'b0010011: return 2;
            7'b0000011: return 3;
            7'b0100011: return 4;
            7'b1100011: return 5;
            7'b1101111: return 6;
            7'b1100111: return 7;
            7'b0110111: return 8;
            7'b0010111: return 9;
            default:    return 0;
        endcase
    endfunction

    function automatic step_t model_eval(input logic [2:0] ph, input int stall,
                                         input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic z, input logic rdy);
        step_t s;
        int    k;
        s = '0;
        s.nxt = ph;
        k = kind_of(op);
        case (ph)
            3'd0: begin
                s.c.mem_req = 1;
                if (rdy) begin
                    s.c.ir_write = 1; s.c.pc_write = 1; s.nxt = 3'd1;
                end else if (stall == TO) begin
                    s.nxt = 3'd5; s.tset = 1; s.cause = 2'd2;
                end
            end
            3'd1: begin
                if (k != 0) s.nxt = 3'd2;
                else begin s.nxt = 3'd5; s.tset = 1; s.cause = 2'd1; end
            end
            3'd2: begin
                s.c.alu_src = (k == 2 || k == 3 || k == 4 || k == 7 || k == 8 || k == 9);
                case (k)
                    1: s.c.alu_op = 4'(f3) + (f7[5] ? 4'd8 : 4'd0);
                    2: s.c.alu_op = 4'(f3) + ((f3 == 3'd5 && f7[5]) ? 4'd8 : 4'd0);
                    5: s.c.alu_op = 4'd8;
                    8: s.c.alu_op = 4'd10;
                    9: s.c.alu_op = 4'd11;
                    default: s.c.alu_op = 4'd0;
                endcase
                if (k == 3 || k == 4) s.nxt = 3'd3;
                else if (k == 6 || k == 7) begin
                    s.c.jump = 1; s.c.pc_write = 1; s.c.pc_src = 1; s.nxt = 3'd4;
                end else if (k == 5) begin
                    s.c.pc_write = z ^ f3[0]; s.c.pc_src = z ^ f3[0];
                    s.c.retire = 1; s.nxt = 3'd0;
                end else s.nxt = 3'd4;
            end
            3'd3: begin
                s.c.mem_req = 1; s.c.addr_sel = 1; s.c.mem_we = (k == 4);
                if (rdy) begin
                    s.c.retire = (k == 4);
                    s.nxt = (k == 4) ? 3'd0 : 3'd4;
                end else if (stall == TO) begin
                    s.nxt = 3'd5; s.tset = 1; s.cause = 2'd2;
                end
            end
            3'd4: begin
                s.c.reg_write = 1; s.c.mem_to_reg = (k == 3); s.c.retire = 1; s.nxt = 3'd0;
            end
            3'd5: s.nxt = 3'd5;
            default: s.nxt = 3'd0;
        endcase
        return s;
    endfunction

    logic [2:0] m_phase;
    int         m_stall;
    logic       m_trap;
    logic [1:0] m_cause;
    logic [3:0] m_instret;

    always @(posedge clk or posedge rst) begin
        step_t s;
        if (rst) begin
            m_phase <= 3'd0; m_stall <= 0; m_trap <= 1'b0; m_cause <= 2'd0; m_instret <= 4'd0;
        end else begin
            s = model_eval(m_phase, m_stall, opcode, funct3, funct7, zero, mem_ready);
            m_phase <= s.nxt;
            if (s.nxt != m_phase) m_stall <= 0;
            else if (!mem_ready)  m_stall <= m_stall + 1;
            if (s.tset) begin m_trap <= 1'b1; m_cause <= s.cause; end
            if (s.c.retire) m_instret <= m_instret + 4'd1;
        end
    end

    always @(negedge clk) begin
        step_t s;
        ctl_t  got;
        if (check_en) begin
            s = rst ? step_t'(0) : model_eval(m_phase, m_stall, opcode, funct3, funct7, zero, mem_ready);
            got = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
                   reg_write, alu_src, mem_to_reg, jump, retire, alu_op};
            n_tests++;
            if (got !== s.c || state !== m_phase || trap !== m_trap ||
                trap_cause !== m_cause || instret !== m_instret) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t: state %0d want %0d, ctl %h want %h, trap %b want %b, cause %0d want %0d, instret %0d want %0d",
                         $time, state, m_phase, got, s.c, trap, m_trap, trap_cause, m_cause, instret, m_instret);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0d want %0d", name, $time, got, exp);
        end
    endtask

    task automatic restart();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op; funct3 = f3; funct7 = f7;
    endtask

    initial begin
        int add_tr[5] = '{0, 1, 2, 4, 0};
        int ld_tr[9]  = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        int br_tr[7]  = '{0, 1, 2, 0, 1, 2, 0};
        int legal_ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        int cnt;
        bit hit;
        int stall_left;
        int trap_cycles;

        @(posedge clk); #1;
        check_en = 1;
        @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_instret", instret, 0);
        chk("reset_trap", trap, 0);
        chk("reset_mem_req", mem_req, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // R-type ADD, zero-wait memory
        set_instr(7'b0110011, 3'b000, 7'b0000000); mem_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("add_state", state, add_tr[i]);
            if (i == 2) chk("add_alu_op", alu_op, 0);
            if (i == 3) chk("add_reg_write", reg_write, 1);
            if (i == 4) chk("add_instret", instret, 1);
            @(posedge clk); #1;
        end

        // LOAD with three wait cycles in MEM
        restart();
        set_instr(7'b0000011, 3'b010, 7'b0000000);
        for (int i = 0; i < 9; i++) begin
            mem_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("load_state", state, ld_tr[i]);
            if (i >= 3 && i <= 6) begin
                chk("load_addr_sel", addr_sel, 1);
                chk("load_mem_we", mem_we, 0);
            end
            if (i == 7) chk("load_mem_to_reg", mem_to_reg, 1);
            if (i == 8) chk("load_instret", instret, 1);
            @(posedge clk); #1;
        end

        // BNE not-taken-on-zero then taken
        restart();
        set_instr(7'b1100011, 3'b001, 7'b0000000); mem_ready = 1;
        for (int i = 0; i < 7; i++) begin
            zero = (i >= 3);
            @(negedge clk);
            chk("bne_state", state, br_tr[i]);
            if (i == 2) begin chk("bne_taken_pcw", pc_write, 1); chk("bne_taken_pcsrc", pc_src, 1); end
            if (i == 5) begin chk("bne_fall_pcw", pc_write, 0); chk("bne_fall_pcsrc", pc_src, 0); end
            if (i == 3) chk("bne_instret1", instret, 1);
            if (i == 6) chk("bne_instret2", instret, 2);
            @(posedge clk); #1;
        end
        zero = 0;

        // Illegal opcode traps and stays trapped
        restart();
        set_instr(7'b1111111, 3'b000, 7'b0000000);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("illegal_state", state, 5);
                chk("illegal_cause", trap_cause, 1);
                chk("illegal_trap", trap, 1);
                chk("illegal_instret", instret, 0);
            end
            @(posedge clk); #1;
        end

        // FETCH timeout
        restart();
        mem_ready = 0;
        cnt = 0; hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (state == 3'd5) hit = 1;
            else if (state == 3'd0) cnt++;
            @(posedge clk); #1;
        end
        chk("timeout_reached", int'(hit), 1);
        chk("timeout_fetch_cycles", cnt, 16);
        chk("timeout_cause", trap_cause, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("timeout_rst_state", state, 0);
        chk("timeout_rst_trap", trap, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1;

        // 17 back-to-back branches wrap the 4-bit counter
        restart();
        set_instr(7'b1100011, 3'b000, 7'b0000000); zero = 0;
        for (int i = 0; i <= 51; i++) begin
            @(negedge clk);
            if (i == 45) chk("wrap_15", instret, 15);
            if (i == 48) chk("wrap_0", instret, 0);
            if (i == 51) chk("wrap_1", instret, 1);
            @(posedge clk); #1;
        end

        // Randomized instruction stream against the reference model
        restart();
        stall_left = 0; trap_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            rst = 1'b0;
            if (m_phase == 3'd5) begin
                trap_cycles++;
                if (trap_cycles > 3) begin rst = 1'b1; trap_cycles = 0; end
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
            end
            if (m_phase == 3'd0) begin
                if ($urandom_range(0, 15) == 0) begin
                    opcode = 7'h7F;
                    for (int t = 0; t < 8; t++) begin
                        logic [6:0] cand;
                        cand = 7'($urandom);
                        if (kind_of(cand) == 0) begin opcode = cand; break; end
                    end
                end else begin
                    opcode = 7'(legal_ops[$urandom_range(0, 8)]);
                end
                funct3 = 3'($urandom);
                funct7 = 7'($urandom);
            end
            zero = 1'($urandom);
            if (stall_left == 0 && $urandom_range(0, 199) == 0) stall_left = 20;
            if (stall_left > 0) begin
                mem_ready = 0;
                stall_left--;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALU_OP_W, default 4, ALU operation code width; minimum 4.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum wait cycles for mem_ready before a bus error.
REQ-003 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-004 Port clk: input, 1 bit, single clock; all state updates on its rising edge.
REQ-005 Port rst: input, 1 bit; reset is asynchronous and active-high.
REQ-006 Ports opcode[6:0], funct3[2:0], funct7[6:0]: inputs from the instruction register; valid from DECODE onward.
REQ-007 Port zero: input, 1 bit, ALU zero flag; sampled in EXEC.
REQ-008 Port mem_ready: input, 1 bit, memory completion strobe.
REQ-009 Ports mem_req, mem_we, addr_sel: outputs, 1 bit each; memory request, write enable, and address select (0 = PC, 1 = ALU result).
REQ-010 Ports ir_write, pc_write, pc_src: outputs, 1 bit each; IR load, PC load, and PC source (0 = PC+4, 1 = branch/jump target).
REQ-011 Ports reg_write, alu_src, mem_to_reg, jump: outputs, 1 bit each; same meanings as in the single-cycle decoder.
REQ-012 Port alu_op[ALU_OP_W-1:0]: output, ALU operation.
REQ-013 Port state[2:0]: output, current FSM state, for debug.
REQ-014 Ports trap, trap_cause[1:0]: outputs; sticky fault flag and its cause (01 = illegal opcode, 10 = bus timeout).
REQ-015 Port instret[CNT_W-1:0]: output, retired-instruction count.
REQ-016 Port retire: output, 1 bit, one-cycle pulse when an instruction retires.

Function
REQ-017 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL return to FETCH on the next edge.
REQ-018 All outputs except state, trap, trap_cause and instret SHALL be combinational functions of state and the inputs, and SHALL be 0 in any state not listed for them.
REQ-019 FETCH: mem_req=1, addr_sel=0; on mem_ready=1: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
REQ-020 DECODE: opcode in {R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC} -> EXEC; any other opcode -> TRAP with trap_cause=01.
REQ-021 EXEC alu_op values:
  - R-type: {funct7[5], funct3}, zero-extended to ALU_OP_W.
  - I-type: {1'b0, funct3}, except SRAI (funct3=101) uses funct7[5].
  - LOAD/STORE: 0.
  - BRANCH: 4'b1000 (subtract).
  - LUI: 4'b1010.
  - AUIPC: 4'b1011.
REQ-022 alu_src SHALL be 1 in EXEC for I, LOAD, STORE, JALR, LUI and AUIPC.
REQ-023 EXEC transitions:
  - R, I, LUI, AUIPC -> WB.
  - LOAD, STORE -> MEM.
  - JAL, JALR: jump=1, pc_write=1, pc_src=1 -> WB.
  - BRANCH: taken = zero XOR funct3[0]; if taken, pc_write=1 and pc_src=1; retire=1; -> FETCH.
REQ-024 MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE. On mem_ready: STORE -> FETCH with retire=1; LOAD -> WB.
REQ-025 WB: reg_write=1, mem_to_reg=1 for LOAD only, retire=1, -> FETCH.
REQ-026 A wait counter SHALL clear on entering FETCH or MEM and increment each cycle mem_ready=0. When it reaches MEM_TIMEOUT with mem_ready still 0, next state is TRAP with trap_cause=10. mem_ready=1 on the timeout cycle completes normally.
REQ-027 TRAP: all control outputs 0; trap=1; trap_cause held; state stays TRAP until rst.
REQ-028 instret SHALL increment by 1 on each retire and wrap from all-ones to 0.
REQ-029 Instruction latency in cycles, counted from FETCH entry with zero-wait memory: BRANCH 3, R/I/LUI/AUIPC/JAL/JALR 4, STORE 4, LOAD 5.

Reset
REQ-030 While rst=1: state=FETCH, wait counter=0, instret=0, trap=0, trap_cause=00, and all combinational outputs forced to 0, including mem_req.
REQ-031 Reset asserted mid-instruction SHALL abort it without retire; fetch restarts on the first edge after rst falls.

Verification
REQ-032 R-type ADD (0110011, f3=000, f7=0), zero-wait memory -> states 0,1,2,4,0; alu_op=0000 in EXEC; reg_write=1 in WB; retire pulse once; instret=1.
REQ-033 LOAD (0000011) with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with addr_sel=1, mem_we=0; WB has mem_to_reg=1; total 8 cycles.
REQ-034 BNE (1100011, f3=001) with zero=0, then with zero=1 -> first case pc_write=1, pc_src=1 in EXEC; second case pc_src=0, pc_write=0; each retires after 3 cycles.
REQ-035 Opcode 1111111 -> TRAP after DECODE; trap=1, trap_cause=01; stays in TRAP 20 cycles; instret unchanged.
REQ-036 mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> TRAP with trap_cause=10 after 16 FETCH cycles; rst pulse -> state=0, trap=0.
REQ-037 CNT_W=4, run 17 back-to-back BRANCH instructions -> instret wraps 15 -> 0 -> 1.
